// File: rtl/wfg_pkg.sv
// Shared definitions for the waveform generator and its PWM DAC stage.
package wfg_pkg;

  // Default sample width shared with the waveform generator.
  localparam int WFG_WIDTH = 8;

  // Width of the attenuation (right-shift) control.
  localparam int AMP_W = 2;

  // PWM DAC run state.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage : wfg_pkg

// File: rtl/pwm_frame_counter.sv
// Free-running PWM frame counter: counts 0..2^WIDTH-1 while running and
// flags the frame boundary (count zero on a running edge).
module pwm_frame_counter
  import wfg_pkg::*;
#(
  parameter int WIDTH = WFG_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  state_t           state,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             is_boundary
);

  logic [WIDTH-1:0] cnt_r;
  logic             run_s;

  // The counter only advances on edges that keep the block in RUN; an edge
  // in RUN with en low aborts the frame, so it must not count as a boundary.
  assign run_s = (state == RUN) && en;

  // Wrapping frame counter; cleared whenever the block is not running.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {WIDTH{1'b0}};
    end else if (run_s) begin
      cnt_r <= cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= {WIDTH{1'b0}};
    end
  end

  assign cnt         = cnt_r;
  assign is_boundary = run_s && (cnt_r == {WIDTH{1'b0}});

endmodule : pwm_frame_counter

// File: rtl/waveform_pwm_dac.sv
// PWM DAC for the waveform generator's sample stream. Each frame lasts
// 2^WIDTH clocks; the attenuated sample is latched at the frame boundary so
// the duty cycle never changes mid-frame.
// Optional feature: define WFG_FRAME_STROBE_EN to add the frame_start port,
// a one-cycle strobe aligned with the first pwm_out cycle of each frame.
module waveform_pwm_dac
  import wfg_pkg::*;
#(
  parameter int WIDTH = WFG_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  input  logic [AMP_W-1:0] amp,
  output logic             pwm_out,
  output logic [WIDTH-1:0] duty
`ifdef WFG_FRAME_STROBE_EN
  ,
  output logic             frame_start
`endif
);

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] cnt_s;
  logic             is_boundary_s;
  logic [WIDTH-1:0] duty_r;
  logic [WIDTH-1:0] duty_eff_s;
  logic             pwm_r;

  pwm_frame_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk        (clk),
    .rst        (rst),
    .state      (state_r),
    .en         (en),
    .cnt        (cnt_s),
    .is_boundary(is_boundary_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: en alone decides between running and idling.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (en) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (en) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Duty in effect for this edge: fresh sample on a boundary, else the latch.
  always_comb begin
    duty_eff_s = duty_r;
    if (is_boundary_s) begin
      duty_eff_s = in >> amp;
    end else begin
      duty_eff_s = duty_r;
    end
  end

  // Duty latch: in and amp are only observed at frame boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_r <= {WIDTH{1'b0}};
    end else if (is_boundary_s) begin
      duty_r <= duty_eff_s;
    end else begin
      duty_r <= duty_r;
    end
  end

  // PWM comparator; forced low whenever the block is not staying in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_r <= 1'b0;
    end else if ((state_r == RUN) && en) begin
      pwm_r <= (cnt_s < duty_eff_s);
    end else begin
      pwm_r <= 1'b0;
    end
  end

  assign pwm_out = pwm_r;
  assign duty    = duty_r;

`ifdef WFG_FRAME_STROBE_EN
  logic frame_start_r;

  // Frame strobe, high for the cycle following each boundary edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= is_boundary_s;
    end
  end

  assign frame_start = frame_start_r;
`endif

endmodule : waveform_pwm_dac

// File: tb/tb_waveform_pwm_dac.sv
// Directed self-checking bench for waveform_pwm_dac (WIDTH = 8).
module tb_waveform_pwm_dac;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] in;
  logic [1:0] amp;
  logic       pwm_out;
  logic [7:0] duty;
`ifdef WFG_FRAME_STROBE_EN
  logic       frame_start;
`endif

  int tests_run;
  int tests_failed;

  waveform_pwm_dac #(
    .WIDTH(8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .in     (in),
    .amp    (amp),
    .pwm_out(pwm_out),
    .duty   (duty)
`ifdef WFG_FRAME_STROBE_EN
    ,
    .frame_start(frame_start)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run = tests_run + 1;
    if (observed !== expected) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Observes 256 cycles starting with the boundary edge. An optional input
  // change is applied after step chg_at.
  task automatic measure_frame(input int chg_at, input logic [7:0] chg_in, input logic [1:0] chg_amp,
                               output int highs, output logic first, output logic last);
    int strobes;
    highs   = 0;
    strobes = 0;
    first   = 1'b0;
    last    = 1'b0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (pwm_out) highs = highs + 1;
      if (i == 0) first = pwm_out;
      if (i == 255) last = pwm_out;
`ifdef WFG_FRAME_STROBE_EN
      if (frame_start) strobes = strobes + 1;
      if (i == 0) check("strobe_first_cycle", {31'd0, frame_start}, 32'd1);
`endif
      if (i == chg_at) begin
        in  = chg_in;
        amp = chg_amp;
      end
    end
`ifdef WFG_FRAME_STROBE_EN
    check("strobe_count", strobes, 32'd1);
`endif
  endtask

  int   h;
  logic f;
  logic l;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    en  = 1'b0;
    in  = 8'd0;
    amp = 2'd0;
    step();
    step();
    check("reset_pwm", {31'd0, pwm_out}, 32'd0);
    check("reset_duty", {24'd0, duty}, 32'd0);
`ifdef WFG_FRAME_STROBE_EN
    check("reset_strobe", {31'd0, frame_start}, 32'd0);
`endif
    rst = 1'b0;
    step();
    check("idle_pwm", {31'd0, pwm_out}, 32'd0);

    // Full scale, in=64
    in  = 8'd64;
    amp = 2'd0;
    en  = 1'b1;
    step();  // E0
    check("e0_pwm_low", {31'd0, pwm_out}, 32'd0);
    measure_frame(-1, 8'd0, 2'd0, h, f, l);
    check("fs_f0_highs", h, 32'd64);
    check("fs_f0_first", {31'd0, f}, 32'd1);
    check("fs_duty", {24'd0, duty}, 32'd64);
    measure_frame(-1, 8'd0, 2'd0, h, f, l);
    check("fs_f1_highs", h, 32'd64);

    // Attenuation: 200>>2 = 50, then amp=3 mid-frame -> 25 next frame
    in  = 8'd200;
    amp = 2'd2;
    measure_frame(-1, 8'd0, 2'd0, h, f, l);
    check("att_highs", h, 32'd50);
    check("att_duty", {24'd0, duty}, 32'd50);
    measure_frame(10, 8'd200, 2'd3, h, f, l);
    check("att_midchg_highs", h, 32'd50);
    measure_frame(-1, 8'd0, 2'd0, h, f, l);
    check("att_amp3_highs", h, 32'd25);
    check("att_amp3_duty", {24'd0, duty}, 32'd25);

    // Extremes: zero for three frames
    in  = 8'd0;
    amp = 2'd0;
    for (int k = 0; k < 3; k++) begin
      measure_frame(-1, 8'd0, 2'd0, h, f, l);
      check("zero_highs", h, 32'd0);
    end
    // Extremes: 255 -> 255 high then 1 low per 256-clock frame
    in = 8'd255;
    for (int k = 0; k < 2; k++) begin
      measure_frame(-1, 8'd0, 2'd0, h, f, l);
      check("max_highs", h, 32'd255);
      check("max_first", {31'd0, f}, 32'd1);
      check("max_last_low", {31'd0, l}, 32'd0);
    end

    // Mid-frame sample change 0 -> 128 at cnt=100
    in = 8'd0;
    measure_frame(-1, 8'd0, 2'd0, h, f, l);
    check("mid_pre_highs", h, 32'd0);
    measure_frame(100, 8'd128, 2'd0, h, f, l);
    check("mid_ignored_highs", h, 32'd0);
    measure_frame(-1, 8'd0, 2'd0, h, f, l);
    check("mid_next_highs", h, 32'd128);

    // Abort at cnt=30
    for (int k = 0; k < 30; k++) step();
    check("abort_pre_pwm", {31'd0, pwm_out}, 32'd1);
    en = 1'b0;
    step();
    check("abort_pwm", {31'd0, pwm_out}, 32'd0);
    step();
    step();
    check("abort_idle_pwm", {31'd0, pwm_out}, 32'd0);
    check("abort_duty_held", {24'd0, duty}, 32'd128);

    // Re-enable: E0 then boundary
    en = 1'b1;
    step();
    check("reen_e0_pwm", {31'd0, pwm_out}, 32'd0);
    measure_frame(-1, 8'd0, 2'd0, h, f, l);
    check("reen_highs", h, 32'd128);
    check("reen_first", {31'd0, f}, 32'd1);

    // Reset mid-run
    for (int k = 0; k < 10; k++) step();
    rst = 1'b1;
    step();
    step();
    check("rst_mid_pwm", {31'd0, pwm_out}, 32'd0);
    check("rst_mid_duty", {24'd0, duty}, 32'd0);
`ifdef WFG_FRAME_STROBE_EN
    check("rst_mid_strobe", {31'd0, frame_start}, 32'd0);
`endif
    rst = 1'b0;
    en  = 1'b0;
    step();
    step();
    step();
    check("post_rst_idle_pwm", {31'd0, pwm_out}, 32'd0);
    check("post_rst_idle_duty", {24'd0, duty}, 32'd0);
    in = 8'd64;
    en = 1'b1;
    step();  // E0
    measure_frame(-1, 8'd0, 2'd0, h, f, l);
    check("post_rst_highs", h, 32'd64);
    check("post_rst_first", {31'd0, f}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_waveform_pwm_dac

// File: doc/waveform_pwm_dac.md
# waveform_pwm_dac

Downstream stage of the waveform generator: consumes its 8-bit sample stream and converts it to a single-bit PWM signal that drives the board's RC-filtered audio/analog output pin. Each PWM frame lasts 2^WIDTH clocks. The sample, attenuated by a selectable right shift, is latched once per frame so the duty cycle never changes mid-frame.

## Interface
- WIDTH, 8: sample width; also sets frame length = 2^WIDTH clocks.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; low forces idle.
- in  in  WIDTH  sample from the waveform generator's out.
- amp  in  2  attenuation: duty = in >> amp (0 = full scale, 3 = 1/8).
- pwm_out  out  1  registered PWM output.
- duty  out  WIDTH  duty value in effect for the current frame.
- frame_start  out  1  one-cycle frame strobe (only with WFG_FRAME_STROBE_EN).

## Operation
- State machine with two states, IDLE and RUN.
- IDLE: cnt=0, pwm_out=0, duty holds its last value. Leaves IDLE on a clock edge with en=1, entering RUN with cnt=0.
- RUN: cnt increments every clock and wraps from 2^WIDTH-1 to 0 with no gap.
- Any edge in RUN with en=0 returns the block to IDLE, aborting the frame: cnt<=0, pwm_out<=0.
- Frame boundary is the RUN edge where cnt==0. On that edge:
  - duty <= in >> amp (logical shift, zero-filled, result WIDTH bits).
  - in and amp are sampled only here; changes at any other time are ignored until the next boundary.
- Every RUN edge: pwm_out <= (cnt < duty_eff). duty_eff is the freshly computed in>>amp on a boundary edge, otherwise the registered duty. The comparison is unsigned, WIDTH bits.
- Boundary cases:
  - duty 0: pwm_out stays 0 for the whole frame.
  - duty 2^WIDTH-1: pwm_out is high 2^WIDTH-1 clocks, low 1 clock per frame.
  - Full-on (100%) is not reachable, by design.
- rst overrides en and everything else.

## Timing
- Reset values: state=IDLE, cnt=0, duty=0, pwm_out=0, frame_start=0.
- Run start: en sampled high at edge E0 → RUN. The first boundary is edge E1, and pwm_out for frame 0 becomes valid after E1.
- Latency: a sample present at a boundary edge appears on pwm_out starting in the cycle after that edge, 1 clock.
- pwm_out high pulse per frame = exactly duty clocks, contiguous, starting at the frame's first cycle.
- Frame period = 2^WIDTH clocks (2560 ns at 100 MHz, WIDTH=8).
- Stopping: en low at edge Ek → pwm_out=0 from the cycle after Ek. Re-enable restarts with the E0/E1 sequence above.
- The upstream generator needs no handshake; sampling is free-running at the boundary.

## Configuration
- WFG_FRAME_STROBE_EN defined:
  - Port frame_start exists.
  - It is registered, high for exactly the one cycle following each boundary edge, aligned with the first pwm_out cycle of the frame.
  - It is 0 in IDLE and after reset.
- Undefined: port frame_start and its register are absent. All other behaviour is identical.

## Structure
- Package wfg_pkg holds:
  - The state typedef (IDLE, RUN).
  - The AMP_W=2 constant.
  - The default WIDTH constant shared with the waveform generator.
- Sub-module pwm_frame_counter holds:
  - The wrapping cnt register.
  - Its is_boundary decode, qualified by RUN.
- The top level holds the FSM, duty latch and comparator.

## Test plan
- Reset: assert rst 2 cycles mid-run → next cycle pwm_out=0, duty=0, frame_start=0, cnt restarts only after en.
- Full scale: en=1, in=8'd64, amp=0 → every frame pwm_out high exactly 64 of 256 clocks, first high cycle one clock after boundary; duty=64.
- Attenuation: in=8'd200, amp=2 → duty=50, 50 high clocks per frame; change amp to 3 mid-frame → current frame stays 50, next frame 25.
- Extremes: in=0 → pwm_out never high over 3 frames; in=255, amp=0 → 255 high + 1 low per frame, period exactly 256 clocks.
- Mid-frame sample change and abort:
  - in changes 0→128 at cnt=100 → no effect until the next boundary.
  - en dropped at cnt=30 → pwm_out=0 one clock later.
  - Re-enable → new frame starts at cnt=0 one clock after en.
- Strobe build (WFG_FRAME_STROBE_EN): run 10 frames with the waveform generator connected → frame_start pulses exactly 10 times, 256 clocks apart, each coincident with the first cycle of a frame.
